cpu_mem_port: RTL and testbench
===============================

Name: cpu_mem_port

Overview:
- MEM-stage memory port controller. It sits directly downstream of the byte read/write modifier.
- It consumes the byte-positioned write data and 2-bit byte-select, latches each load/store request and runs the req/resp handshake with the data memory (or D-cache).
- It stalls the pipeline until the access completes and returns the raw 16-bit read word for byte extraction.

Parameters:
- TIMEOUT_CYCLES, 64: max BUSY cycles before abort (used only with optional feature).
- CNT_W, 7: width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_read  in  1  MEM-stage load request (level, held until stall drops)
- req_write  in  1  MEM-stage store request (level)
- addr  in  16 (lc3b_word)  byte address
- wdata  in  16 (lc3b_word)  write data, already byte-positioned
- wrsel  in  2 (lc3b_sel)  byte enables; [0]=low byte, [1]=high byte
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  16  word-aligned address {addr[15:1],1'b0}
- mem_wdata  out  16  latched write data
- mem_byte_enable  out  2  latched byte enables (forced 2'b11 for reads)
- mem_resp  in  1  memory completion, one-cycle pulse
- mem_rdata  in  16  read data, valid with mem_resp
- stall  out  1  freeze pipeline
- rdata  out  16  captured read word
- rdata_valid  out  1  one-cycle pulse; rdata holds a completed load
- bus_err  out  1  one-cycle abort pulse (optional feature only; else tied 0)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_read, mem_write, rdata_valid, bus_err = 0; stall deasserts combinationally.
  - Latches and rdata = 16'h0000; mem_byte_enable = 2'b00.
  - Reset mid-BUSY drops strobes immediately; a later mem_resp is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = req_read|req_write (combinational).
  - On a request: latch addr/wdata/wrsel and op, go to BUSY.
  - req_write and req_read both high: write wins, read is dropped.
  - No request: stay in IDLE, strobes 0.
- BUSY:
  - stall=1. Exactly one of mem_read/mem_write is high, from the latched op.
  - Address, data and enables stay stable for the whole state.
  - On mem_resp: capture mem_rdata into rdata (loads only; stores leave rdata unchanged), go to DONE.
  - Strobes drop in the cycle after mem_resp.
- DONE:
  - stall=0; rdata_valid=1 for a load, 0 for a store.
  - Requests are ignored, because the pipeline advances past the completing instruction at this edge.
  - Always go to IDLE.
- Latency: request seen in cycle 0, strobe high from cycle 1.
  - mem_resp in cycle k (k>=1) gives DONE in cycle k+1.
  - Minimum stall is 2 cycles (0 and 1).
- Back-to-back: a new request can be accepted in the IDLE cycle following DONE.
- Inputs are sampled only on the IDLE->BUSY edge. Changes while BUSY have no effect.
- mem_resp in IDLE or DONE is ignored.
- wrsel=2'b00 with req_write: the write is still issued with enables 00 (no-op store, full handshake).

Optional Feature:
- Macro: CPU_MEM_TIMEOUT_EN
- Defined:
  - A CNT_W counter clears on entry to BUSY and increments each BUSY cycle without mem_resp.
  - When it reaches TIMEOUT_CYCLES: drop strobes, pulse bus_err for one cycle, go to DONE with rdata_valid=0 and rdata unchanged.
  - mem_resp in the same cycle as the limit takes priority: normal completion, no bus_err.
- Undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

Decomposition:
- lc3b_types already holds lc3b_word and lc3b_sel.
- Add to it: enum mem_port_state_t {MP_IDLE, MP_BUSY, MP_DONE} and localparam MEM_BE_WORD=2'b11.
- No sub-module: single FSM plus latches. The timeout counter stays inline under the macro.

Test Plan:
- Load, resp latency 1:
  - Stimulus: req_read=1, addr=16'h1235; mem_resp in cycle 1 with mem_rdata=16'hBEEF.
  - Required: mem_address=16'h1234, mem_byte_enable=11, stall in cycles 0-1, cycle 2 rdata=16'hBEEF with rdata_valid=1.
- Store, high byte, resp latency 5:
  - Stimulus: req_write=1, addr=16'h0041, wdata=16'hAB00, wrsel=2'b10.
  - Required: mem_write high cycles 1-5, mem_wdata=16'hAB00, enables=10, stall cycles 0-5, no rdata_valid, rdata unchanged.
- Simultaneous req_read and req_write:
  - Required: only mem_write asserted; the read never issues.
- Input change while BUSY:
  - Stimulus: addr switches to 16'hFFFF in cycle 2.
  - Required: mem_address stays at the latched value.
- Mid-BUSY reset:
  - Stimulus: rst_n=0 in cycle 3, then mem_resp after release.
  - Required: strobes 0 immediately, state IDLE, no rdata_valid.
- Timeout (CPU_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4), no mem_resp:
  - Required: bus_err pulse in the cycle after the count reaches 4, then DONE, rdata_valid=0.
  - Repeat with mem_resp exactly on the limit cycle: normal completion, bus_err=0.

Source files
------------

// File: rtl/cpu_mem_port_pkg.sv
// Shared LC-3b word/select types plus the memory-port FSM state encoding.
package cpu_mem_port_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_sel;

  typedef enum logic [1:0] {
    MP_IDLE,
    MP_BUSY,
    MP_DONE
  } mem_port_state_t;

  localparam lc3b_sel MEM_BE_WORD = 2'b11;

endpackage

// File: rtl/cpu_mem_port.sv
// MEM-stage memory port: latches one load/store, runs req/resp with memory, stalls the pipe.
// Optional bus-timeout abort is enabled by defining CPU_MEM_TIMEOUT_EN.
module cpu_mem_port
  import cpu_mem_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req_read,
  input  logic     req_write,
  input  lc3b_word addr,
  input  lc3b_word wdata,
  input  lc3b_sel  wrsel,
  output logic     mem_read,
  output logic     mem_write,
  output lc3b_word mem_address,
  output lc3b_word mem_wdata,
  output lc3b_sel  mem_byte_enable,
  input  logic     mem_resp,
  input  lc3b_word mem_rdata,
  output logic     stall,
  output lc3b_word rdata,
  output logic     rdata_valid,
  output logic     bus_err
);

  mem_port_state_t state;

`ifdef CPU_MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
  assign bus_err    = 1'b0;
`endif

  // Address is word-aligned at capture so the low byte select alone picks the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= MP_IDLE;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= 2'b00;
      rdata           <= '0;
      rdata_valid     <= 1'b0;
`ifdef CPU_MEM_TIMEOUT_EN
      cnt             <= '0;
      bus_err         <= 1'b0;
`endif
    end else begin
      rdata_valid <= 1'b0;
`ifdef CPU_MEM_TIMEOUT_EN
      bus_err     <= 1'b0;
`endif
      case (state)
        MP_IDLE: begin
          if (req_read || req_write) begin
            mem_address     <= {addr[15:1], 1'b0};
            mem_wdata       <= wdata;
            mem_write       <= req_write;
            mem_read        <= !req_write;
            mem_byte_enable <= req_write ? wrsel : MEM_BE_WORD;
            state           <= MP_BUSY;
`ifdef CPU_MEM_TIMEOUT_EN
            cnt             <= '0;
`endif
          end
        end
        MP_BUSY: begin
          if (mem_resp) begin
            if (mem_read) rdata <= mem_rdata;
            rdata_valid <= mem_read;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            state       <= MP_DONE;
          end
`ifdef CPU_MEM_TIMEOUT_EN
          // The abort lands after exactly TIMEOUT_CYCLES busy cycles.
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            bus_err   <= 1'b1;
            state     <= MP_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        MP_DONE: state <= MP_IDLE;
        default: state <= MP_IDLE;
      endcase
    end
  end

  // Stall must rise in the request cycle itself, before the FSM has moved.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      stall = (state == MP_BUSY) || ((state == MP_IDLE) && (req_read || req_write));
    end
  end

endmodule

// File: tb/tb_cpu_mem_port.sv
// Directed self-checking bench for cpu_mem_port (timeout scenarios need CPU_MEM_TIMEOUT_EN).
module tb_cpu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read, req_write;
  logic [15:0] addr, wdata;
  logic [1:0]  wrsel;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        bus_err;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_rdata;
  logic        saw_read;

  always #5 clk = ~clk;

  cpu_mem_port #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write),
    .addr(addr), .wdata(wdata), .wrsel(wrsel),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err)
  );

  task automatic test_reset();
    req_read = 1'b1;
    #3;
    total++; if (stall !== 1'b0) $display("[TB] FAIL rst_stall: got %b want 0", stall); else passed++;
    total++; if ({mem_read, mem_write, rdata_valid, bus_err} !== 4'b0000) $display("[TB] FAIL rst_strobes: got %b want 0000", {mem_read, mem_write, rdata_valid, bus_err}); else passed++;
    total++; if (rdata !== 16'h0000) $display("[TB] FAIL rst_rdata: got %h want 0000", rdata); else passed++;
    total++; if (mem_byte_enable !== 2'b00) $display("[TB] FAIL rst_be: got %b want 00", mem_byte_enable); else passed++;
    total++; if ({mem_address, mem_wdata} !== 32'h0) $display("[TB] FAIL rst_latches: got %h want 0", {mem_address, mem_wdata}); else passed++;
    req_read = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    exp_rdata = 16'h0000;
  endtask

  task automatic test_load_latency1();
    @(negedge clk);
    req_read = 1'b1; addr = 16'h1235; #1;
    total++; if (stall !== 1'b1) $display("[TB] FAIL ld_c0_stall: got %b want 1", stall); else passed++;
    total++; if (mem_read !== 1'b0) $display("[TB] FAIL ld_c0_read: got %b want 0", mem_read); else passed++;
    @(negedge clk);
    total++; if ({mem_read, mem_write, stall} !== 3'b101) $display("[TB] FAIL ld_c1_ctl: got %b want 101", {mem_read, mem_write, stall}); else passed++;
    total++; if (mem_address !== 16'h1234) $display("[TB] FAIL ld_c1_addr: got %h want 1234", mem_address); else passed++;
    total++; if (mem_byte_enable !== 2'b11) $display("[TB] FAIL ld_c1_be: got %b want 11", mem_byte_enable); else passed++;
    mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = 16'h0000; #1;
    total++; if ({stall, mem_read, rdata_valid} !== 3'b001) $display("[TB] FAIL ld_c2_ctl: got %b want 001", {stall, mem_read, rdata_valid}); else passed++;
    total++; if (rdata !== 16'hBEEF) $display("[TB] FAIL ld_c2_rdata: got %h want beef", rdata); else passed++;
    exp_rdata = 16'hBEEF;
    req_read = 1'b0;
    @(negedge clk);
    total++; if ({rdata_valid, stall, mem_read} !== 3'b000) $display("[TB] FAIL ld_c3_idle: got %b want 000", {rdata_valid, stall, mem_read}); else passed++;
  endtask

  task automatic test_store_latency5();
    @(negedge clk);
    req_write = 1'b1; addr = 16'h0041; wdata = 16'hAB00; wrsel = 2'b10; #1;
    total++; if (stall !== 1'b1) $display("[TB] FAIL st_c0_stall: got %b want 1", stall); else passed++;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total++; if ({mem_write, mem_read, stall} !== 3'b101) $display("[TB] FAIL st_c%0d_ctl: got %b want 101", c, {mem_write, mem_read, stall}); else passed++;
      total++; if ({mem_address, mem_wdata, mem_byte_enable} !== {16'h0040, 16'hAB00, 2'b10}) $display("[TB] FAIL st_c%0d_bus: got %h/%h/%b want 0040/ab00/10", c, mem_address, mem_wdata, mem_byte_enable); else passed++;
      if (c == 5) begin mem_resp = 1'b1; mem_rdata = 16'h1357; end
    end
    @(negedge clk);
    mem_resp = 1'b0; #1;
    total++; if ({stall, mem_write, rdata_valid} !== 3'b000) $display("[TB] FAIL st_c6_ctl: got %b want 000", {stall, mem_write, rdata_valid}); else passed++;
    total++; if (rdata !== exp_rdata) $display("[TB] FAIL st_c6_rdata: got %h want %h", rdata, exp_rdata); else passed++;
    req_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    saw_read = 1'b0;
    @(negedge clk);
    req_read = 1'b1; req_write = 1'b1; addr = 16'h0100; wdata = 16'h1234; wrsel = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (mem_read) saw_read = 1'b1;
      if (c == 1) begin
        total++; if ({mem_write, mem_byte_enable} !== 3'b101) $display("[TB] FAIL sim_c1_write: got %b want 101", {mem_write, mem_byte_enable}); else passed++;
        mem_resp = 1'b1; mem_rdata = 16'hDEAD;
      end else begin
        mem_resp = 1'b0;
      end
      if (c == 2) begin
        total++; if ({rdata_valid, rdata} !== {1'b0, exp_rdata}) $display("[TB] FAIL sim_c2_rdata: got %b/%h want 0/%h", rdata_valid, rdata, exp_rdata); else passed++;
        req_read = 1'b0; req_write = 1'b0;
      end
    end
    total++; if (saw_read !== 1'b0) $display("[TB] FAIL sim_no_read: got %b want 0", saw_read); else passed++;
  endtask

  task automatic test_busy_input_change();
    @(negedge clk);
    req_read = 1'b1; addr = 16'h2000;
    @(negedge clk);
    total++; if (mem_address !== 16'h2000) $display("[TB] FAIL chg_c1_addr: got %h want 2000", mem_address); else passed++;
    @(negedge clk);
    addr = 16'hFFFF; wdata = 16'hFFFF; wrsel = 2'b00; req_write = 1'b1;
    @(negedge clk);
    total++; if ({mem_address, mem_byte_enable, mem_read, mem_write} !== {16'h2000, 2'b11, 2'b10}) $display("[TB] FAIL chg_c3_bus: got %h/%b/%b%b want 2000/11/10", mem_address, mem_byte_enable, mem_read, mem_write); else passed++;
    mem_resp = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    mem_resp = 1'b0;
    total++; if ({rdata_valid, rdata} !== {1'b1, 16'h5A5A}) $display("[TB] FAIL chg_c4_rdata: got %b/%h want 1/5a5a", rdata_valid, rdata); else passed++;
    exp_rdata = 16'h5A5A;
    req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_resp();
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_resp = 1'b0; #1;
    total++; if ({rdata_valid, stall, mem_read, mem_write, rdata} !== {4'b0000, exp_rdata}) $display("[TB] FAIL stray_resp: got %b/%h want 0000/%h", {rdata_valid, stall, mem_read, mem_write}, rdata, exp_rdata); else passed++;
  endtask

  task automatic test_noop_store();
    @(negedge clk);
    req_write = 1'b1; addr = 16'h0300; wdata = 16'h00FF; wrsel = 2'b00;
    @(negedge clk);
    total++; if ({mem_write, mem_byte_enable, mem_address} !== {1'b1, 2'b00, 16'h0300}) $display("[TB] FAIL noop_c1: got %b/%b/%h want 1/00/0300", mem_write, mem_byte_enable, mem_address); else passed++;
    @(negedge clk);
    total++; if ({mem_write, stall} !== 2'b11) $display("[TB] FAIL noop_c2_hold: got %b want 11", {mem_write, stall}); else passed++;
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0; #1;
    total++; if ({mem_write, stall, rdata_valid} !== 3'b000) $display("[TB] FAIL noop_c3_done: got %b want 000", {mem_write, stall, rdata_valid}); else passed++;
    req_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_write = 1'b1; addr = 16'h0010; wdata = 16'h00CD; wrsel = 2'b01;
    @(negedge clk);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    req_write = 1'b0; req_read = 1'b1; addr = 16'h0021; #1;
    total++; if ({stall, mem_read, mem_write} !== 3'b000) $display("[TB] FAIL b2b_done: got %b want 000", {stall, mem_read, mem_write}); else passed++;
    @(negedge clk); #1;
    total++; if ({stall, mem_read} !== 2'b10) $display("[TB] FAIL b2b_idle: got %b want 10", {stall, mem_read}); else passed++;
    @(negedge clk);
    total++; if ({mem_read, mem_address} !== {1'b1, 16'h0020}) $display("[TB] FAIL b2b_issue: got %b/%h want 1/0020", mem_read, mem_address); else passed++;
    mem_resp = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    mem_resp = 1'b0;
    total++; if ({rdata_valid, rdata} !== {1'b1, 16'h1111}) $display("[TB] FAIL b2b_rdata: got %b/%h want 1/1111", rdata_valid, rdata); else passed++;
    exp_rdata = 16'h1111;
    req_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_busy_reset();
    @(negedge clk);
    req_read = 1'b1; addr = 16'h3000;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; #1;
    total++; if ({mem_read, mem_write, stall} !== 3'b000) $display("[TB] FAIL mrst_drop: got %b want 000", {mem_read, mem_write, stall}); else passed++;
    req_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 16'h9999;
    @(negedge clk);
    mem_resp = 1'b0;
    total++; if ({rdata_valid, mem_read, stall, rdata} !== {3'b000, 16'h0000}) $display("[TB] FAIL mrst_after: got %b/%h want 000/0000", {rdata_valid, mem_read, stall}, rdata); else passed++;
    exp_rdata = 16'h0000;
  endtask

`ifdef CPU_MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    req_read = 1'b1; addr = 16'h4000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++; if ({mem_read, bus_err} !== 2'b10) $display("[TB] FAIL to_c%0d: got %b want 10", c, {mem_read, bus_err}); else passed++;
    end
    @(negedge clk); #1;
    total++; if ({bus_err, mem_read, rdata_valid, stall} !== 4'b1000) $display("[TB] FAIL to_abort: got %b want 1000", {bus_err, mem_read, rdata_valid, stall}); else passed++;
    total++; if (rdata !== exp_rdata) $display("[TB] FAIL to_rdata: got %h want %h", rdata, exp_rdata); else passed++;
    req_read = 1'b0;
    @(negedge clk);
    total++; if (bus_err !== 1'b0) $display("[TB] FAIL to_pulse: got %b want 0", bus_err); else passed++;
  endtask

  task automatic test_timeout_resp_on_limit();
    @(negedge clk);
    req_read = 1'b1; addr = 16'h5000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) begin mem_resp = 1'b1; mem_rdata = 16'h7777; end
    end
    @(negedge clk);
    mem_resp = 1'b0;
    total++; if ({bus_err, rdata_valid, rdata} !== {2'b01, 16'h7777}) $display("[TB] FAIL to_limit: got %b%b/%h want 01/7777", bus_err, rdata_valid, rdata); else passed++;
    exp_rdata = 16'h7777;
    req_read = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0;
    addr = '0; wdata = '0; wrsel = '0; mem_resp = 1'b0; mem_rdata = '0;
    exp_rdata = '0;
    test_reset();
    test_load_latency1();
    test_store_latency5();
    test_simultaneous();
    test_busy_input_change();
    test_stray_resp();
    test_noop_store();
    test_back_to_back();
    test_mid_busy_reset();
`ifdef CPU_MEM_TIMEOUT_EN
    test_timeout();
    test_timeout_resp_on_limit();
`endif
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
